// File: rtl/cia_serial_port.sv
// CIA serial data register shift controller: transmits bytes on CNT/SP clocked by
// timer A underflows in output mode, and receives bytes clocked by external CNT in input mode.
module cia_serial_port (
  input  logic       clk,
  input  logic       clk7_en,
  input  logic       reset,
  input  logic       wr,
  input  logic       sdr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  input  logic       spmode,
  input  logic       tmra_ovf,
  input  logic       cnt_in,
  input  logic       sp_in,
  output logic       cnt_out,
  output logic       sp_out,
  output logic       irq
);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e     state_q, state_d;
  logic [7:0] sdr_reg_q, sdr_reg_d;
  logic       buf_full_q, buf_full_d;
  logic [7:0] shreg_q, shreg_d;
  logic [3:0] ucnt_q, ucnt_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic       cnt_dly_q, cnt_dly_d;
  logic       mode_q, mode_d;
  logic       cnt_out_q, cnt_out_d;
  logic       sp_out_q, sp_out_d;
  logic       irq_q, irq_d;
  logic       cpu_wr;
  logic       load;

  assign cpu_wr = sdr & wr;

  // NOTE: every variable assigned below gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    sdr_reg_d  = sdr_reg_q;
    buf_full_d = buf_full_q;
    shreg_d    = shreg_q;
    ucnt_d     = ucnt_q;
    bitcnt_d   = bitcnt_q;
    cnt_out_d  = cnt_out_q;
    sp_out_d   = sp_out_q;
    irq_d      = 1'b0;
    cnt_dly_d  = cnt_in;
    mode_d     = spmode;
    load       = 1'b0;

    if (spmode) begin
      if (!mode_q) bitcnt_d = 3'd0;
      if (state_q == IDLE) begin
        load = buf_full_q;
      end else if (tmra_ovf) begin
        ucnt_d = ucnt_q + 4'd1;
        if (!ucnt_q[0]) begin
          cnt_out_d = 1'b0;
          // Data only moves on CNT falling edges; the first falling edge keeps bit 7.
          if (ucnt_q >= 4'd2) begin
            shreg_d  = {shreg_q[6:0], 1'b0};
            sp_out_d = shreg_q[6];
          end
        end else begin
          cnt_out_d = 1'b1;
        end
        if (ucnt_q == 4'd15) begin
          irq_d = 1'b1;
          if (buf_full_q) load = 1'b1;
          else            state_d = IDLE;
        end
      end
      if (load) begin
        shreg_d    = sdr_reg_q;
        sp_out_d   = sdr_reg_q[7];
        ucnt_d     = 4'd0;
        buf_full_d = 1'b0;
        state_d    = SHIFT;
      end
      // A write in the load cycle refills the buffer for the following byte.
      if (cpu_wr) begin
        sdr_reg_d  = data_in;
        buf_full_d = 1'b1;
      end
    end else begin
      state_d    = IDLE;
      buf_full_d = 1'b0;
      ucnt_d     = 4'd0;
      cnt_out_d  = 1'b1;
      sp_out_d   = 1'b1;
      if (cpu_wr) sdr_reg_d = data_in;
      if (cnt_in && !cnt_dly_q) begin
        shreg_d  = {shreg_q[6:0], sp_in};
        bitcnt_d = bitcnt_q + 3'd1;
        if (bitcnt_q == 3'd7) begin
          sdr_reg_d = {shreg_q[6:0], sp_in};
          irq_d     = 1'b1;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk) begin
    if (clk7_en) begin
      if (reset) begin
        state_q    <= IDLE;
        sdr_reg_q  <= 8'h00;
        buf_full_q <= 1'b0;
        shreg_q    <= 8'h00;
        ucnt_q     <= 4'd0;
        bitcnt_q   <= 3'd0;
        cnt_dly_q  <= 1'b1;
        mode_q     <= 1'b0;
        cnt_out_q  <= 1'b1;
        sp_out_q   <= 1'b1;
        irq_q      <= 1'b0;
      end else begin
        state_q    <= state_d;
        sdr_reg_q  <= sdr_reg_d;
        buf_full_q <= buf_full_d;
        shreg_q    <= shreg_d;
        ucnt_q     <= ucnt_d;
        bitcnt_q   <= bitcnt_d;
        cnt_dly_q  <= cnt_dly_d;
        mode_q     <= mode_d;
        cnt_out_q  <= cnt_out_d;
        sp_out_q   <= sp_out_d;
        irq_q      <= irq_d;
      end
    end
  end

  assign data_out = (sdr & ~wr) ? sdr_reg_q : 8'h00;
  assign cnt_out  = cnt_out_q;
  assign sp_out   = sp_out_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_cia_serial_port.sv
// Scoreboard bench for cia_serial_port: stimulus pushes expected bytes, a monitor
// reassembles the serial stream / reads the received byte on each irq and compares.
module tb_cia_serial_port;

  logic       clk = 1'b0;
  logic       clk7_en = 1'b1;
  logic       reset = 1'b1;
  logic       wr = 1'b0;
  logic       sdr = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       spmode = 1'b1;
  logic       tmra_ovf = 1'b0;
  logic       cnt_in = 1'b1;
  logic       sp_in = 1'b1;
  logic       cnt_out, sp_out, irq;

  cia_serial_port dut (
    .clk(clk), .clk7_en(clk7_en), .reset(reset), .wr(wr), .sdr(sdr),
    .data_in(data_in), .data_out(data_out), .spmode(spmode), .tmra_ovf(tmra_ovf),
    .cnt_in(cnt_in), .sp_in(sp_in), .cnt_out(cnt_out), .sp_out(sp_out), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       out_mode;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- monitor ----------------
  logic       prev_cnt = 1'b1;
  logic       prev_sp = 1'b1;
  logic [7:0] acc = 8'h00;
  int         nbits = 0;
  logic       pend_in = 1'b0;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (clk7_en) begin
      // A receiver samples SP just before the CNT rising edge.
      if (spmode && !reset && cnt_out && !prev_cnt) begin
        acc = {acc[6:0], prev_sp};
        nbits++;
      end
      if (!spmode && !reset) check("in_mode_pins_idle", 32'({cnt_out, sp_out}), 32'h3);
      if (irq) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_irq actual=irq required=no_irq (t=%0t)", $time);
        end else if (spmode) begin
          e = exp_q.pop_front();
          check("irq_mode", 32'(spmode), 32'(e.out_mode));
          check("out_bits", 32'(nbits), 32'd8);
          check("out_byte", 32'(acc), 32'(e.data));
          nbits = 0;
        end else begin
          pend_in = 1'b1;
        end
      end
      if (reset || !spmode) nbits = 0;
    end
    if (pend_in && !wr && sdr) begin
      e = exp_q.pop_front();
      check("irq_mode", 32'(spmode), 32'(e.out_mode));
      check("in_byte", 32'(data_out), 32'(e.data));
      pend_in = 1'b0;
    end
    prev_cnt = cnt_out;
    prev_sp  = sp_out;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    int n;
    n = $urandom_range(0, 1);
    repeat (n) begin
      clk7_en = 1'b0;
      @(negedge clk);
      #2;
    end
    clk7_en = 1'b1;
    @(negedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic wr_byte(input logic [7:0] d, input bit push);
    wr = 1'b1;
    data_in = d;
    if (push) exp_q.push_back(exp_t'{out_mode: 1'b1, data: d});
    tick();
    wr = 1'b0;
  endtask

  task automatic ovf();
    tmra_ovf = 1'b1;
    tick();
    tmra_ovf = 1'b0;
  endtask

  task automatic in_byte(input logic [7:0] b, input bit wr_last);
    for (int i = 7; i >= 0; i--) begin
      cnt_in = 1'b0;
      sp_in = b[i];
      idle($urandom_range(1, 2));
      cnt_in = 1'b1;
      if (i == 0) begin
        exp_q.push_back(exp_t'{out_mode: 1'b0, data: b});
        if (wr_last) begin
          wr = 1'b1;
          data_in = ~b;
        end
      end
      tick();
      wr = 1'b0;
      idle($urandom_range(0, 1));
    end
  endtask

  task automatic out_stream(input int n);
    logic [7:0] nb;
    int wpos;
    nb = 8'($urandom);
    wr_byte(nb, 1'b1);
    tick();
    for (int i = 0; i < n; i++) begin
      wpos = $urandom_range(0, 15);
      for (int s = 0; s < 16; s++) begin
        if (i < n - 1 && s == wpos) begin
          nb = 8'($urandom);
          wr_byte(nb, 1'b1);
        end
        ovf();
        idle($urandom_range(0, 2));
      end
    end
    idle(2);
  endtask

  // ---------------- test sequence ----------------
  initial begin : stim
    logic [7:0] rb;
    idle(2);
    reset = 1'b0;
    check("reset_cnt_out", 32'(cnt_out), 32'h1);
    check("reset_sp_out", 32'(sp_out), 32'h1);
    check("reset_irq", 32'(irq), 32'h0);
    check("reset_data_out", 32'(data_out), 32'h00);

    // Reset in the middle of a byte (after 5 strobes, ucnt = 5).
    wr_byte(8'h5A, 1'b0);
    tick();
    repeat (5) ovf();
    check("pre_reset_cnt_low", 32'(cnt_out), 32'h0);
    reset = 1'b1;
    tick();
    check("midrst_cnt_out", 32'(cnt_out), 32'h1);
    check("midrst_sp_out", 32'(sp_out), 32'h1);
    check("midrst_irq", 32'(irq), 32'h0);
    check("midrst_data_out", 32'(data_out), 32'h00);
    reset = 1'b0;
    repeat (3) ovf();
    check("midrst_buffer_empty", 32'(cnt_out), 32'h1);

    // Single output byte, strobes spaced out.
    wr_byte(8'hA5, 1'b1);
    tick();
    repeat (16) begin
      ovf();
      idle(3);
    end
    idle(4);
    check("single_cnt_idle", 32'(cnt_out), 32'h1);
    check("single_one_irq", 32'(exp_q.size()), 32'd0);

    // Back-to-back: second byte queued mid-transfer must follow without a gap.
    wr_byte(8'hF0, 1'b1);
    tick();
    repeat (8) ovf();
    wr_byte(8'h0F, 1'b1);
    repeat (8) ovf();
    check("b2b_reload_sp", 32'(sp_out), 32'h0);
    ovf();
    check("b2b_no_gap_cnt", 32'(cnt_out), 32'h0);
    repeat (15) ovf();
    idle(3);

    // Write coinciding with the completing strobe: one idle cycle, then load.
    wr_byte(8'h81, 1'b1);
    tick();
    repeat (15) ovf();
    tmra_ovf = 1'b1;
    wr = 1'b1;
    data_in = 8'h3C;
    exp_q.push_back(exp_t'{out_mode: 1'b1, data: 8'h3C});
    #1;
    check("read_during_write", 32'(data_out), 32'h00);
    tick();
    tmra_ovf = 1'b0;
    wr = 1'b0;
    check("woc_idle_cnt", 32'(cnt_out), 32'h1);
    check("woc_hold_sp", 32'(sp_out), 32'h1);
    ovf();
    check("woc_load_sp", 32'(sp_out), 32'h0);
    check("woc_ovf_ignored", 32'(cnt_out), 32'h1);
    repeat (16) ovf();
    idle(3);

    // Input mode: CB, then static CNT must not raise irq.
    spmode = 1'b0;
    tick();
    in_byte(8'hCB, 1'b0);
    idle(10);
    check("in_single_irq", 32'(exp_q.size()), 32'd0);

    // Partial byte discarded by a trip through output mode.
    for (int i = 0; i < 3; i++) begin
      cnt_in = 1'b0;
      sp_in = 1'($urandom);
      tick();
      cnt_in = 1'b1;
      tick();
    end
    spmode = 1'b1;
    tick();
    spmode = 1'b0;
    tick();
    rb = 8'($urandom);
    in_byte(rb, 1'b0);

    // CPU write on the completing CNT edge: received byte wins.
    rb = 8'($urandom);
    in_byte(rb, 1'b1);
    idle(3);

    // Abort after 6 strobes.
    spmode = 1'b1;
    tick();
    wr_byte(8'h00, 1'b0);
    tick();
    repeat (6) ovf();
    check("abort_pre_sp", 32'(sp_out), 32'h0);
    spmode = 1'b0;
    tick();
    check("abort_cnt_out", 32'(cnt_out), 32'h1);
    check("abort_sp_out", 32'(sp_out), 32'h1);
    repeat (4) ovf();
    spmode = 1'b1;
    tick();
    repeat (4) ovf();
    check("abort_no_resume", 32'(cnt_out), 32'h1);

    // Randomized traffic in both modes.
    for (int r = 0; r < 4; r++) begin
      spmode = 1'b1;
      tick();
      out_stream($urandom_range(1, 3));
      spmode = 1'b0;
      tick();
      repeat ($urandom_range(1, 2)) begin
        rb = 8'($urandom);
        in_byte(rb, 1'b0);
      end
      idle(2);
    end

    // Drain with a bounded wait.
    for (int t = 0; t < 200 && (exp_q.size() != 0 || pend_in); t++) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cia_serial_port.md
# cia_serial_port

CIA serial data register (SDR) shift controller. It sequences byte transfers on the CIA serial port, using timer A underflow (`tmra_ovf`) as the output bit clock and timer A control bit 6 (`spmode`) as the direction select. It sits beside the CIA timer A block inside each CIA instance. It drives the external CNT/SP pins and the SP interrupt source bit of the CIA ICR.

## Interface
No parameters.
- `clk` input 1 — system clock.
- `clk7_en` input 1 — clock enable. All state updates occur only on `clk` edges where `clk7_en`=1.
- `reset` input 1 — reset; synchronous, active-high, sampled when `clk7_en`=1.
- `wr` input 1 — bus write strobe.
- `sdr` input 1 — SDR register select.
- `data_in` input 8 — bus write data.
- `data_out` output 8 — `sdr_reg` when `sdr & ~wr`, otherwise 8'h00.
- `spmode` input 1 — 1 = output mode, 0 = input mode (from timer A control register).
- `tmra_ovf` input 1 — timer A underflow strobe; one `clk7_en` cycle wide.
- `cnt_in` input 1 — external CNT pin, already synchronized.
- `sp_in` input 1 — external SP pin, already synchronized.
- `cnt_out` output 1 — CNT drive, idle high.
- `sp_out` output 1 — SP drive, idle high.
- `irq` output 1 — SP interrupt pulse: one `clk7_en` period per completed byte.

## Operation
- **Registers**
  - `sdr_reg[7:0]`: CPU-visible register.
  - `buf_full`: output buffer flag.
  - `shreg[7:0]`: shift register.
  - `ucnt[3:0]`: underflow counter (output mode).
  - `bitcnt[2:0]`: received-bit counter (input mode).
  - `cnt_d`: previous `cnt_in`.
  - `state`: IDLE or SHIFT.
- **Reset values:** `sdr_reg`=0, `buf_full`=0, `state`=IDLE, `ucnt`=0, `bitcnt`=0, `cnt_out`=1, `sp_out`=1, `irq`=0, `cnt_d`=1.
- **CPU write** (`sdr & wr`): `sdr_reg` <= `data_in` in both modes. In output mode, `buf_full` is also set to 1.
- **Output mode, IDLE:** if `buf_full`=1 → `shreg` <= `sdr_reg`, `sp_out` <= `sdr_reg[7]`, `ucnt` <= 0, `buf_full` <= 0, `state` <= SHIFT.
- **Output mode, SHIFT:** on each `tmra_ovf`, with k = `ucnt`:
  - k even: `cnt_out` <= 0. If k ≥ 2, also `shreg` <= `shreg` << 1 and `sp_out` <= `shreg[6]`. Data changes only on CNT falling edges.
  - k odd: `cnt_out` <= 1 (rising edge; the receiver samples here).
  - `ucnt` <= k+1, wrapping 15 → 0.
- **Byte completion** (k=15 with `tmra_ovf`): `irq` pulses.
  - If `buf_full`=1 (registered value) → reload exactly as the IDLE load, remaining in SHIFT with no gap.
  - Else → IDLE, `cnt_out`=1, `sp_out` holds the last bit.
- **Write coinciding with completion:** the completion uses the old `buf_full`=0 → goes IDLE. The load follows on the next `clk7_en` cycle (one-cycle gap, CNT stays high).
- **`tmra_ovf` is ignored** in IDLE and in input mode.
- **Input mode:**
  - `cnt_d` <= `cnt_in` every `clk7_en` cycle.
  - Rising edge = `cnt_in & ~cnt_d`. On a rising edge: `shreg` <= {`shreg[6:0]`,`sp_in`}, `bitcnt` <= `bitcnt`+1.
  - Rising edge with `bitcnt`=7: `sdr_reg` <= {`shreg[6:0]`,`sp_in`}, `irq` pulses, `bitcnt` wraps to 0.
  - A CPU write in the same cycle as input completion: the received byte wins.
  - `cnt_out` and `sp_out` are held at 1.
- **Mode change 1→0 (mid-operation):** abort the transfer. `state` <= IDLE, `buf_full` <= 0, `ucnt` <= 0, `cnt_out` <= 1, `sp_out` <= 1, no `irq`.
- **Mode change 0→1:** `bitcnt` <= 0. The partial received byte is discarded.
- **Reset mid-transfer:** all registers return to their reset values on that same edge.

## Timing
- Write at `clk7_en` edge N → `buf_full`=1 after N → load after N+1 (`sp_out` = bit 7 valid) → first `tmra_ovf` from N+2 onward drives CNT low.
- One byte = 16 `tmra_ovf` strobes. A bit period is 2 timer A underflows, MSB first.
- `irq` is registered: high from the completing edge until the next `clk7_en` edge. At most one pulse per byte.
- Back-to-back output (buffer refilled before completion): no idle CNT cycles between bytes.
- Input: `irq` is asserted on the `clk7_en` edge following the 8th `cnt_in` rising edge.
- `data_out` is combinational from `sdr_reg`, `sdr`, `wr`.

## Test plan
- **Reset:** assert `reset` during SHIFT with `ucnt`=5 → next edge `cnt_out`=1, `sp_out`=1, `irq`=0, `data_out` read = 8'h00, `buf_full`=0.
- **Single output byte:** `spmode`=1, write 8'hA5, pulse `tmra_ovf` 16 times, 4 cycles apart.
  - Sampling `sp_out` at the 8 CNT rising edges yields 1,0,1,0,0,1,0,1.
  - Exactly one `irq` pulse after the 16th strobe; `cnt_out` then stays 1.
- **Back-to-back output:** write 8'hF0, then write 8'h0F before the 16th strobe → the second byte starts with no gap. Serial stream = F0 then 0F; two `irq` pulses.
- **Write on completion:** write 8'h3C on the same edge as the 16th strobe → one IDLE cycle, then reload; `sp_out`=0 (bit 7 of 3C) on the following edge.
- **Input byte:** `spmode`=0, drive 8 `cnt_in` rising edges with `sp_in` = 1,1,0,0,1,0,1,1 → `sdr_reg` read = 8'hCB and one `irq` pulse. Holding `cnt_in` static produces no further `irq`.
- **Abort:** clear `spmode` after 6 strobes of an output byte → `cnt_out`=1, `sp_out`=1, no `irq`. Later `tmra_ovf` strobes have no effect.
